qpu_exu_event_queue: RTL and testbench
======================================

# qpu_exu_event_queue

Timed event queue directly downstream of the QIU write-back port. It buffers each `{tdata, oprand, edata}` event bundle produced by the QIU and owns the QPU timeline counter, which it also returns to the QIU as its time base. It issues each bundle to the analog/waveform interface when the timeline reaches the bundle's timestamp, and flags late events.

## Interface
- `EVT_W`, default 64, width of an event data word (`QPU_EVENT_WIRE_WIDTH`).
- `EVT_N`, default 8, number of event operand bits (`QPU_EVENT_NUM`).
- `TIME_W`, default 32, timestamp/timeline width (`QPU_TIME_WIDTH`).
- `DEPTH`, default 8, number of queue entries; must be a power of 2, ≥2.

Ports:
- `clk`, in, 1, single clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `evq_i_valid`, in, 1, write-back valid (from `qiu_o_valid`).
- `evq_i_ready`, out, 1, write-back ready (to `qiu_o_ready`).
- `evq_i_edata`, in, EVT_W, event data word.
- `evq_i_oprand`, in, EVT_N, event operand mask.
- `evq_i_tdata`, in, TIME_W, absolute issue timestamp.
- `tmr_en`, in, 1, timeline run enable.
- `tmr_clr`, in, 1, synchronous timeline clear.
- `evq_flush`, in, 1, synchronous queue flush.
- `evq_o_clk`, out, TIME_W, current timeline value (to `qiu_i_clk`).
- `evq_o_valid`, out, 1, one-cycle issue pulse; no backpressure.
- `evq_o_edata`, out, EVT_W, issued event data.
- `evq_o_oprand`, out, EVT_N, issued operand mask.
- `evq_o_time`, out, TIME_W, timeline value at which the event was issued.
- `evq_o_late_err`, out, 1, sticky late-event flag.
- `evq_o_cnt`, out, log2(DEPTH)+1, queue occupancy.
- `evq_o_empty`, out, 1, queue empty.

## Operation
- **Timeline.** `evq_o_clk` is a `TIME_W`-bit register.
  - `tmr_clr=1`: the register goes to 0 next cycle. This has priority over counting.
  - Otherwise, `tmr_en=1`: the register increments by 1 and wraps modulo 2^TIME_W.
  - Otherwise it holds its value.
- **Enqueue.**
  - `evq_i_ready = ~full`, where full means `cnt==DEPTH`.
  - A push happens when `valid & ready`: the entry `{tdata, oprand, edata}` is written at the write pointer.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - Pointers are `log2(DEPTH)+1` bits wide and wrap naturally.
- **Issue decision.** Evaluated each cycle on the registered head entry and the current timeline value T.
  - `diff = head.tdata - T`, computed modulo 2^TIME_W.
  - due: `diff==0`.
  - late: `diff[TIME_W-1]==1`, i.e. the timestamp is up to 2^(TIME_W-1) ticks in the past.
  - pop: `~empty & tmr_en & (due | late)`. At most one pop per cycle.
  - A pop with `late=1` sets `evq_o_late_err`.
- **Issue output.** Registered. In the cycle after a pop:
  - `evq_o_valid=1`;
  - `evq_o_edata` and `evq_o_oprand` carry the head entry's fields;
  - `evq_o_time=T`.
  - In all other cycles, `evq_o_valid=0` and the data outputs hold their last values.
- **Same-timestamp entries.** The QIU merges events that share a timestamp. Two queue entries with equal `tdata` are therefore an error: the second one is issued the following cycle as late and sets `evq_o_late_err`.
- **Flush.** `evq_flush=1`:
  - empties the queue (pointers go to 0);
  - clears `evq_o_late_err`;
  - suppresses any push or pop in that cycle;
  - does not affect the timeline.
- **Push to empty queue.** Push and issue are never bypassed. A push into an empty queue is issued no earlier than the next cycle.

## Timing
- Reset values (async assert, sync deassert handled externally):
  - `evq_o_clk=0`, `evq_o_valid=0`, `evq_o_edata=0`, `evq_o_oprand=0`, `evq_o_time=0`, `evq_o_late_err=0`, `evq_o_cnt=0`;
  - `evq_o_empty=1`, `evq_i_ready=1`.
- Reset asserted mid-operation discards all queued entries.
- Issue latency: a pop at timeline T produces `evq_o_valid` one cycle later. This is a fixed 1-cycle offset that downstream compensates for.
- Push-to-earliest-issue latency: 2 cycles (write, pop, registered output).
- `evq_o_cnt` and `evq_o_empty` are registered and reflect pushes and pops one cycle after they occur.
- `evq_i_ready` is combinational from the registered count. There is no combinational path from `evq_i_valid` to `evq_i_ready`.
- Throughput: 1 push and 1 pop per cycle when not full.
- `tmr_en=0` freezes both the timeline and issue. Entries remain queued.

## Test plan
Parameters for all scenarios: TIME_W=8, DEPTH=4.

1. **Reset.** Assert `rst_n=0` mid-stream with 2 entries queued -> all outputs take their reset values immediately; after release, `cnt=0` and `ready=1`.
2. **Basic timed issue.** `tmr_en=1` from T=0; push tdata=5, oprand=8'h03, edata=64'hA5 at T=1 -> exactly one `evq_o_valid` pulse, in the cycle where `evq_o_clk=6`, with `evq_o_time=5`, oprand=8'h03, edata=64'hA5, `late_err=0`.
3. **Full and backpressure.** Push tdata=100, 101, 102, 103 back to back -> `ready=0` and `cnt=4`; a 5th valid is held. At T=100 the pop occurs; `ready=1` next cycle and the 5th push is accepted.
4. **Late event.** Timeline at 20; push tdata=10 -> issued 2 cycles after the push, `late_err=1`. The flag stays 1 through later on-time issues until `evq_flush`.
5. **Wrap-around.** Timeline at 250; push tdata=3 -> not late (diff=9); issue occurs when the timeline wraps to 3, with `evq_o_time=3`.
6. **Flush and clear.** With 3 entries queued and `late_err=1`, pulse `evq_flush` together with `tmr_clr` -> next cycle `cnt=0`, `empty=1`, `late_err=0`, `evq_o_clk=0`, and no `evq_o_valid` pulse ever appears for the flushed entries.

Source files
------------

// File: rtl/qpu_exu_event_queue.sv
// qpu_exu_event_queue
//
// Timed event queue sitting behind the QIU write-back port. Buffers
// {tdata, oprand, edata} bundles, owns the QPU timeline counter (returned
// to the QIU as its time base) and issues each bundle when the timeline
// reaches its timestamp. Bundles whose timestamp is already in the past
// are issued immediately and raise a sticky late flag.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   evq_i_*           write-back handshake and event bundle from the QIU
//   tmr_en, tmr_clr   timeline run enable / synchronous clear
//   evq_flush         synchronous queue flush (also clears late flag)
//   evq_o_clk         current timeline value
//   evq_o_valid       one-cycle issue pulse with edata/oprand/time
//   evq_o_late_err    sticky late-event flag
//   evq_o_cnt/empty   queue occupancy
module qpu_exu_event_queue #(
   parameter int EVT_W  = 64,
   parameter int EVT_N  = 8,
   parameter int TIME_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     evq_i_valid,
   output logic                     evq_i_ready,
   input  logic [EVT_W-1:0]         evq_i_edata,
   input  logic [EVT_N-1:0]         evq_i_oprand,
   input  logic [TIME_W-1:0]        evq_i_tdata,
   input  logic                     tmr_en,
   input  logic                     tmr_clr,
   input  logic                     evq_flush,
   output logic [TIME_W-1:0]        evq_o_clk,
   output logic                     evq_o_valid,
   output logic [EVT_W-1:0]         evq_o_edata,
   output logic [EVT_N-1:0]         evq_o_oprand,
   output logic [TIME_W-1:0]        evq_o_time,
   output logic                     evq_o_late_err,
   output logic [$clog2(DEPTH):0]   evq_o_cnt,
   output logic                     evq_o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [TIME_W-1:0] mem_t_q [DEPTH];
   logic [EVT_N-1:0]  mem_o_q [DEPTH];
   logic [EVT_W-1:0]  mem_e_q [DEPTH];

   logic [PW-1:0]     wptr_q, rptr_q, cnt_q;
   logic [TIME_W-1:0] tl_q;
   logic              valid_q, late_err_q;
   logic [EVT_W-1:0]  edata_q;
   logic [EVT_N-1:0]  oprand_q;
   logic [TIME_W-1:0] time_q;

   logic              full, empty, push, pop, due, late;
   logic [TIME_W-1:0] head_t, diff;
   logic [AW-1:0]     waddr, raddr;

   assign waddr  = wptr_q[AW-1:0];
   assign raddr  = rptr_q[AW-1:0];
   assign head_t = mem_t_q[raddr];

   assign full   = (cnt_q == PW'(DEPTH));
   assign empty  = (cnt_q == '0);

   // Modular difference: a negative result (MSB set) means the timestamp
   // lies up to half the timeline range in the past.
   assign diff   = head_t - tl_q;
   assign due    = (diff == '0);
   assign late   = diff[TIME_W-1];

   // Ready depends only on the registered count, never on evq_i_valid.
   assign push   = evq_i_valid & ~full & ~evq_flush;
   assign pop    = ~empty & tmr_en & (due | late) & ~evq_flush;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_t_q[waddr] <= evq_i_tdata;
         mem_o_q[waddr] <= evq_i_oprand;
         mem_e_q[waddr] <= evq_i_edata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         tl_q       <= '0;
         valid_q    <= 1'b0;
         late_err_q <= 1'b0;
         edata_q    <= '0;
         oprand_q   <= '0;
         time_q     <= '0;
      end else begin
         if (tmr_clr) begin
            tl_q <= '0;
         end else if (tmr_en) begin
            tl_q <= tl_q + TIME_W'(1);
         end

         if (evq_flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (push) begin
               wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
               rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
               2'b10:   cnt_q <= cnt_q + PW'(1);
               2'b01:   cnt_q <= cnt_q - PW'(1);
               default: cnt_q <= cnt_q;
            endcase
         end

         if (evq_flush) begin
            late_err_q <= 1'b0;
         end else if (pop && late) begin
            late_err_q <= 1'b1;
         end

         valid_q <= pop;
         if (pop) begin
            edata_q  <= mem_e_q[raddr];
            oprand_q <= mem_o_q[raddr];
            time_q   <= tl_q;
         end
      end
   end

   assign evq_i_ready    = ~full;
   assign evq_o_clk      = tl_q;
   assign evq_o_valid    = valid_q;
   assign evq_o_edata    = edata_q;
   assign evq_o_oprand   = oprand_q;
   assign evq_o_time     = time_q;
   assign evq_o_late_err = late_err_q;
   assign evq_o_cnt      = cnt_q;
   assign evq_o_empty    = empty;

endmodule

// File: tb/tb_qpu_exu_event_queue.sv
module tb_qpu_exu_event_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        evq_i_valid = 1'b0;
   logic        evq_i_ready;
   logic [63:0] evq_i_edata = '0;
   logic [7:0]  evq_i_oprand = '0;
   logic [7:0]  evq_i_tdata = '0;
   logic        tmr_en = 1'b0;
   logic        tmr_clr = 1'b0;
   logic        evq_flush = 1'b0;
   logic [7:0]  evq_o_clk;
   logic        evq_o_valid;
   logic [63:0] evq_o_edata;
   logic [7:0]  evq_o_oprand;
   logic [7:0]  evq_o_time;
   logic        evq_o_late_err;
   logic [2:0]  evq_o_cnt;
   logic        evq_o_empty;

   int checks = 0;
   int errors = 0;

   qpu_exu_event_queue #(.EVT_W(64), .EVT_N(8), .TIME_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .evq_i_valid(evq_i_valid), .evq_i_ready(evq_i_ready),
      .evq_i_edata(evq_i_edata), .evq_i_oprand(evq_i_oprand), .evq_i_tdata(evq_i_tdata),
      .tmr_en(tmr_en), .tmr_clr(tmr_clr), .evq_flush(evq_flush),
      .evq_o_clk(evq_o_clk), .evq_o_valid(evq_o_valid), .evq_o_edata(evq_o_edata),
      .evq_o_oprand(evq_o_oprand), .evq_o_time(evq_o_time), .evq_o_late_err(evq_o_late_err),
      .evq_o_cnt(evq_o_cnt), .evq_o_empty(evq_o_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of bundles, an integer timeline and the
   // last-issued values, advanced once per clock edge from the inputs.
   typedef struct {
      logic [7:0]  t;
      logic [7:0]  o;
      logic [63:0] e;
   } ent_t;

   ent_t        mq[$];
   logic [7:0]  m_T = '0;
   logic        m_valid = 1'b0;
   logic [63:0] m_e = '0;
   logic [7:0]  m_o = '0;
   logic [7:0]  m_time = '0;
   logic        m_late = 1'b0;
   bit          m_pop, m_push, m_is_late;
   int          m_ahead;
   ent_t        m_h;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_T = '0; m_valid = 1'b0; m_e = '0; m_o = '0; m_time = '0; m_late = 1'b0;
      end else begin
         m_pop = 0;
         m_is_late = 0;
         if (!evq_flush && mq.size() > 0 && tmr_en) begin
            m_h = mq[0];
            // ticks until the timestamp, in 0..255; >=128 means in the past
            m_ahead = (int'(m_h.t) - int'(m_T) + 256) % 256;
            m_is_late = (m_ahead >= 128);
            m_pop = (m_ahead == 0) || m_is_late;
         end
         m_push = evq_i_valid && (mq.size() < 4) && !evq_flush;
         m_valid = m_pop;
         if (m_pop) begin
            m_e = m_h.e; m_o = m_h.o; m_time = m_T;
            if (m_is_late) m_late = 1'b1;
            void'(mq.pop_front());
         end
         if (evq_flush) begin
            mq.delete();
            m_late = 1'b0;
         end
         if (m_push) mq.push_back('{t: evq_i_tdata, o: evq_i_oprand, e: evq_i_edata});
         if (tmr_clr) m_T = '0;
         else if (tmr_en) m_T = m_T + 8'd1;
      end
   end

   always @(negedge clk) begin
      chk("clk", evq_o_clk, m_T);
      chk("valid", evq_o_valid, m_valid);
      chk("edata", evq_o_edata, m_e);
      chk("oprand", evq_o_oprand, m_o);
      chk("time", evq_o_time, m_time);
      chk("late_err", evq_o_late_err, m_late);
      chk("cnt", evq_o_cnt, mq.size());
      chk("empty", evq_o_empty, mq.size() == 0);
      chk("ready", evq_i_ready, mq.size() < 4);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [7:0] t, input logic [7:0] o, input logic [63:0] e,
                          input int budget);
      bit r;
      bit done;
      done = 0;
      evq_i_valid = 1'b1; evq_i_tdata = t; evq_i_oprand = o; evq_i_edata = e;
      for (int n = 0; n < budget && !done; n++) begin
         r = evq_i_ready;
         tick();
         done = r;
      end
      evq_i_valid = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      bit seen;
      seen = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         tick();
         seen = evq_o_valid;
      end
      if (!seen) chk(name, 0, 1);
   endtask

   task automatic count_valid(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (evq_o_valid) c++;
      end
   endtask

   task automatic wait_clk(input logic [7:0] v, input int budget);
      bit hit;
      hit = (evq_o_clk == v);
      for (int n = 0; n < budget && !hit; n++) begin
         tick();
         hit = (evq_o_clk == v);
      end
      if (!hit) chk("timeline_timeout", 0, 1);
   endtask

   initial begin
      int c;
      logic [7:0] tcur;
      #1 rst_n = 1'b0;
      tick();
      chk("rst_cnt", evq_o_cnt, 3'd0);
      chk("rst_ready", evq_i_ready, 1'b1);
      chk("rst_empty", evq_o_empty, 1'b1);
      tick();
      rst_n = 1'b1;
      tmr_en = 1'b1;
      tick();
      chk("t_start", evq_o_clk, 8'd1);

      // basic timed issue: push tdata=5 at T=1
      do_push(8'd5, 8'h03, 64'hA5, 4);
      wait_valid("basic_timeout", 20);
      chk("basic_clk", evq_o_clk, 8'd6);
      chk("basic_time", evq_o_time, 8'd5);
      chk("basic_oprand", evq_o_oprand, 8'h03);
      chk("basic_edata", evq_o_edata, 64'hA5);
      chk("basic_late", evq_o_late_err, 1'b0);
      count_valid(6, c);
      chk("basic_single_pulse", c, 0);

      // fill and backpressure
      do_push(8'd100, 8'h10, 64'h100, 4);
      do_push(8'd101, 8'h11, 64'h101, 4);
      do_push(8'd102, 8'h12, 64'h102, 4);
      do_push(8'd103, 8'h13, 64'h103, 4);
      chk("full_cnt", evq_o_cnt, 3'd4);
      chk("full_ready", evq_i_ready, 1'b0);
      do_push(8'd104, 8'h14, 64'h104, 300);
      chk("fifth_accept_clk", evq_o_clk, 8'd102);
      for (int n = 0; n < 20 && !evq_o_empty; n++) tick();
      chk("drain_empty", evq_o_empty, 1'b1);

      // late event with timeline at 20
      tmr_clr = 1'b1;
      tick();
      tmr_clr = 1'b0;
      chk("clr_clk", evq_o_clk, 8'd0);
      wait_clk(8'd19, 40);
      do_push(8'd10, 8'h21, 64'hDEAD, 4);
      tick();
      chk("late_valid", evq_o_valid, 1'b1);
      chk("late_time", evq_o_time, 8'd20);
      chk("late_flag", evq_o_late_err, 1'b1);
      do_push(8'd30, 8'h22, 64'hBEEF, 4);
      wait_valid("ontime_timeout", 20);
      chk("ontime_time", evq_o_time, 8'd30);
      chk("late_sticky", evq_o_late_err, 1'b1);
      evq_flush = 1'b1;
      tick();
      evq_flush = 1'b0;
      chk("flush_late", evq_o_late_err, 1'b0);

      // wrap-around: timeline 250, tdata 3
      wait_clk(8'd249, 300);
      do_push(8'd3, 8'h55, 64'h5555_0003, 4);
      wait_valid("wrap_timeout", 30);
      chk("wrap_time", evq_o_time, 8'd3);
      chk("wrap_clk", evq_o_clk, 8'd4);
      chk("wrap_late", evq_o_late_err, 1'b0);

      // duplicate timestamps: the second one goes out late
      tcur = evq_o_clk + 8'd5;
      do_push(tcur, 8'h61, 64'h61, 4);
      do_push(tcur, 8'h62, 64'h62, 4);
      repeat (10) tick();
      chk("dup_late", evq_o_late_err, 1'b1);
      chk("dup_oprand", evq_o_oprand, 8'h62);

      // flush with three queued entries, together with timeline clear
      tcur = evq_o_clk;
      do_push(tcur + 8'd50, 8'h71, 64'h71, 4);
      do_push(tcur + 8'd60, 8'h72, 64'h72, 4);
      do_push(tcur + 8'd70, 8'h73, 64'h73, 4);
      chk("pre_flush_cnt", evq_o_cnt, 3'd3);
      evq_flush = 1'b1;
      tmr_clr = 1'b1;
      tick();
      evq_flush = 1'b0;
      tmr_clr = 1'b0;
      chk("flush_cnt", evq_o_cnt, 3'd0);
      chk("flush_empty", evq_o_empty, 1'b1);
      chk("flush_late2", evq_o_late_err, 1'b0);
      chk("flush_clk", evq_o_clk, 8'd0);
      count_valid(260, c);
      chk("flush_no_issue", c, 0);

      // reset mid-stream with two entries queued
      tcur = evq_o_clk;
      do_push(tcur + 8'd40, 8'h81, 64'h81, 4);
      do_push(tcur + 8'd41, 8'h82, 64'h82, 4);
      chk("pre_rst_cnt", evq_o_cnt, 3'd2);
      rst_n = 1'b0;
      #1;
      chk("arst_clk", evq_o_clk, 8'd0);
      chk("arst_valid", evq_o_valid, 1'b0);
      chk("arst_edata", evq_o_edata, 64'd0);
      chk("arst_oprand", evq_o_oprand, 8'd0);
      chk("arst_time", evq_o_time, 8'd0);
      chk("arst_late", evq_o_late_err, 1'b0);
      chk("arst_cnt", evq_o_cnt, 3'd0);
      chk("arst_empty", evq_o_empty, 1'b1);
      chk("arst_ready", evq_i_ready, 1'b1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_cnt", evq_o_cnt, 3'd0);
      chk("post_rst_ready", evq_i_ready, 1'b1);
      count_valid(300, c);
      chk("post_rst_no_issue", c, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
